// File: rtl/cp0_pkg.sv
// CP0 shared constants: register numbers, exception codes and field positions.
package cp0_pkg;
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;

  localparam int STATUS_IE    = 0;
  localparam int STATUS_EXL   = 1;
  localparam int STATUS_IM_LO = 8;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_IP_LO  = 8;
endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: divided Count, Compare match latches a pending bit
// that only a Compare write clears.
module cp0_timer #(
  parameter int COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        timer_ip
);
  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [DW-1:0] div;
  logic          tick;
  logic [31:0]   count_inc;

  assign tick      = (div == DW'(COUNT_DIV - 1));
  assign count_inc = count + 32'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      compare  <= '0;
      div      <= '0;
      timer_ip <= 1'b0;
    end else begin
      if (count_we) begin
        count <= wdata;
        div   <= '0;
      end else if (tick) begin
        count <= count_inc;
        div   <= '0;
      end else begin
        div <= div + DW'(1);
      end
      if (compare_we) compare <= wdata;
      // A Compare write acknowledges the timer even if a match lands this edge
      if (compare_we)
        timer_ip <= 1'b0;
      else if (!count_we && tick && count_inc == compare)
        timer_ip <= 1'b1;
    end
  end
endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: Status/Cause/EPC, interrupt pending and eret target.
// Define CP0_TIMER_EN to build the Count/Compare timer (cp0_timer).
module cp0_regfile
  import cp0_pkg::*;
#(
  parameter int HW_INT_W  = 6,
  parameter int COUNT_DIV = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [HW_INT_W-1:0] hw_int,
  input  logic                mtc0_en,
  input  logic [4:0]          mtc0_addr,
  input  logic [31:0]         mtc0_data,
  input  logic [4:0]          mfc0_addr,
  output logic [31:0]         mfc0_data,
  input  logic                exc_we,
  input  logic [4:0]          exc_code,
  input  logic [31:0]         exc_epc,
  input  logic                eret,
  output logic                cp0_intr,
  output logic [31:0]         cp0_epc,
  output logic                cp0_exl
);
  logic [7:0]  im;
  logic        ie, exl;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic [4:0]  exc_r;
  logic [31:0] epc;
  logic [5:0]  hw6;
  logic        ip15;
  logic [7:0]  ip;
  logic        st_we, cause_we, epc_we;

  if (HW_INT_W >= 6) begin : g_hw_full
    assign hw6 = hw_int[5:0];
  end else begin : g_hw_pad
    assign hw6 = {{(6-HW_INT_W){1'b0}}, hw_int};
  end

  assign st_we    = mtc0_en && mtc0_addr == CP0_STATUS;
  assign cause_we = mtc0_en && mtc0_addr == CP0_CAUSE;
  assign epc_we   = mtc0_en && mtc0_addr == CP0_EPC;

`ifdef CP0_TIMER_EN
  logic [31:0] count, compare;
  logic        timer_ip;

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (mtc0_en && mtc0_addr == CP0_COUNT),
    .compare_we (mtc0_en && mtc0_addr == CP0_COMPARE),
    .wdata      (mtc0_data),
    .count      (count),
    .compare    (compare),
    .timer_ip   (timer_ip)
  );
  assign ip15 = timer_ip;
`else
  assign ip15 = ip_hw[5];
`endif

  assign ip = {ip15, ip_hw[4:0], ip_sw};

  // Field-level priority: exception > eret > mtc0; unrelated fields still take mtc0
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      im    <= '0;
      ie    <= 1'b0;
      exl   <= 1'b0;
      ip_sw <= '0;
      ip_hw <= '0;
      exc_r <= '0;
      epc   <= '0;
    end else begin
      ip_hw <= hw6;
      if (st_we) begin
        im <= mtc0_data[STATUS_IM_LO +: 8];
        ie <= mtc0_data[STATUS_IE];
      end
      if (exc_we)     exl <= 1'b1;
      else if (eret)  exl <= 1'b0;
      else if (st_we) exl <= mtc0_data[STATUS_EXL];
      if (cause_we) ip_sw <= mtc0_data[CAUSE_IP_LO +: 2];
      if (exc_we) begin
        epc   <= exc_epc;
        exc_r <= exc_code;
      end else if (epc_we) begin
        epc <= mtc0_data;
      end
    end
  end

  always_comb begin
    mfc0_data = '0;
    case (mfc0_addr)
`ifdef CP0_TIMER_EN
      CP0_COUNT:   mfc0_data = count;
      CP0_COMPARE: mfc0_data = compare;
`endif
      CP0_STATUS:  mfc0_data = {16'b0, im, 6'b0, exl, ie};
      CP0_CAUSE:   mfc0_data = {16'b0, ip, 1'b0, exc_r, 2'b0};
      CP0_EPC:     mfc0_data = epc;
      default:     mfc0_data = '0;
    endcase
  end

  assign cp0_intr = ie & ~exl & |(ip & im);
  assign cp0_epc  = epc;
  assign cp0_exl  = exl;
endmodule

// File: tb/tb_cp0_regfile.sv
// Directed vector bench for cp0_regfile (timer checks follow CP0_TIMER_EN).
module tb_cp0_regfile;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  hw_int;
  logic        mtc0_en;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic        exc_we;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        eret;
  logic        cp0_intr;
  logic [31:0] cp0_epc;
  logic        cp0_exl;

  int n_cmp = 0;
  int n_bad = 0;

  cp0_regfile #(.HW_INT_W(6), .COUNT_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .hw_int(hw_int),
    .mtc0_en(mtc0_en), .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data),
    .mfc0_addr(mfc0_addr), .mfc0_data(mfc0_data),
    .exc_we(exc_we), .exc_code(exc_code), .exc_epc(exc_epc), .eret(eret),
    .cp0_intr(cp0_intr), .cp0_epc(cp0_epc), .cp0_exl(cp0_exl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [5:0]  hw;
    logic        exc;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        eret;
    logic [4:0]  ra;
    logic [31:0] exp_rd;
    logic        exp_intr;
    logic        exp_exl;
    logic [31:0] exp_epc;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    mtc0_en = 1'b0; exc_we = 1'b0; eret = 1'b0;
  endtask

  task automatic edge_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle();
    mtc0_en = 1'b1; mtc0_addr = a; mtc0_data = d;
    edge_tick();
    idle();
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] exp);
    mfc0_addr = a;
    #1;
    chk(nm, mfc0_data, exp);
  endtask

  initial begin
    //            we   wa     wd            hw     exc  code  epc           eret ra     exp_rd        intr exl  exp_epc
    vt[0]  = '{1'b1, 5'd12, 32'h0000_0401, 6'h00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd12, 32'h0000_0401, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 5'd0,  32'h0,         6'h01, 1'b0, 5'd0, 32'h0,        1'b0, 5'd13, 32'h0000_0400, 1'b1, 1'b0, 32'h0};
    vt[2]  = '{1'b1, 5'd12, 32'h0000_0001, 6'h01, 1'b0, 5'd0, 32'h0,        1'b0, 5'd12, 32'h0000_0001, 1'b0, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 5'd12, 32'h0000_0401, 6'h00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd13, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 5'd0,  32'h0,         6'h01, 1'b0, 5'd0, 32'h0,        1'b0, 5'd13, 32'h0000_0400, 1'b1, 1'b0, 32'h0};
    vt[5]  = '{1'b0, 5'd0,  32'h0,         6'h01, 1'b1, 5'd8, 32'h8000_0040, 1'b0, 5'd13, 32'h0000_0420, 1'b0, 1'b1, 32'h8000_0040};
    vt[6]  = '{1'b0, 5'd0,  32'h0,         6'h01, 1'b0, 5'd0, 32'h0,        1'b0, 5'd12, 32'h0000_0403, 1'b0, 1'b1, 32'h8000_0040};
    vt[7]  = '{1'b0, 5'd0,  32'h0,         6'h01, 1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'h0000_0401, 1'b1, 1'b0, 32'h8000_0040};
    vt[8]  = '{1'b0, 5'd0,  32'h0,         6'h01, 1'b0, 5'd0, 32'h0,        1'b0, 5'd14, 32'h8000_0040, 1'b1, 1'b0, 32'h8000_0040};
    vt[9]  = '{1'b1, 5'd12, 32'hFFFF_FFFF, 6'h00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd12, 32'h0000_FF03, 1'b0, 1'b1, 32'h8000_0040};
    vt[10] = '{1'b1, 5'd13, 32'hFFFF_FFFF, 6'h00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd13, 32'h0000_0320, 1'b0, 1'b1, 32'h8000_0040};
    vt[11] = '{1'b1, 5'd12, 32'h0000_0301, 6'h00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd12, 32'h0000_0301, 1'b1, 1'b0, 32'h8000_0040};
    vt[12] = '{1'b1, 5'd14, 32'hDEAD_BEEF, 6'h00, 1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd14, 32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678};
    vt[13] = '{1'b1, 5'd12, 32'h0000_0303, 6'h00, 1'b0, 5'd0, 32'h0,        1'b1, 5'd12, 32'h0000_0301, 1'b1, 1'b0, 32'h1234_5678};
    vt[14] = '{1'b1, 5'd5,  32'hFFFF_FFFF, 6'h00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd5,  32'h0000_0000, 1'b1, 1'b0, 32'h1234_5678};
    vt[15] = '{1'b0, 5'd0,  32'h0,         6'h00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd13, 32'h0000_0300, 1'b1, 1'b0, 32'h1234_5678};
    vt[16] = '{1'b1, 5'd13, 32'h0000_0000, 6'h00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd13, 32'h0000_0000, 1'b0, 1'b0, 32'h1234_5678};
    vt[17] = '{1'b1, 5'd14, 32'hCAFE_F00D, 6'h00, 1'b0, 5'd0, 32'h0,        1'b0, 5'd14, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D};

    rst_n = 1'b0; hw_int = '0; mtc0_addr = '0; mtc0_data = '0; mfc0_addr = '0;
    exc_code = '0; exc_epc = '0;
    idle();
    repeat (3) edge_tick();

    // Reset state: every address reads 0 while reset is held
    for (int a = 0; a < 32; a++) rd($sformatf("reset rd%0d", a), 5'(a), 32'h0);
    chk("reset intr", {31'b0, cp0_intr}, 32'h0);
    chk("reset exl", {31'b0, cp0_exl}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      mtc0_en = vt[i].we; mtc0_addr = vt[i].wa; mtc0_data = vt[i].wd;
      hw_int = vt[i].hw; exc_we = vt[i].exc; exc_code = vt[i].code;
      exc_epc = vt[i].epc; eret = vt[i].eret; mfc0_addr = vt[i].ra;
      edge_tick();
      idle();
      chk($sformatf("v%0d rd", i), mfc0_data, vt[i].exp_rd);
      chk($sformatf("v%0d intr", i), {31'b0, cp0_intr}, {31'b0, vt[i].exp_intr});
      chk($sformatf("v%0d exl", i), {31'b0, cp0_exl}, {31'b0, vt[i].exp_exl});
      chk($sformatf("v%0d epc", i), cp0_epc, vt[i].exp_epc);
    end

    // mfc0 of a register being written this cycle returns the old value
    mtc0_en = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'h1111_1111; mfc0_addr = 5'd14;
    #1;
    chk("same-cycle old", mfc0_data, 32'hCAFE_F00D);
    edge_tick();
    idle();
    chk("same-cycle new", mfc0_data, 32'h1111_1111);

`ifdef CP0_TIMER_EN
    mtc0(5'd9, 32'hFFFF_FFFE);
    rd("count load", 5'd9, 32'hFFFF_FFFE);
    mtc0(5'd11, 32'h0000_0001);
    rd("compare load", 5'd11, 32'h0000_0001);
    repeat (4) edge_tick();
    rd("timer not yet", 5'd13, 32'h0000_0000);
    edge_tick();
    rd("timer set", 5'd13, 32'h0000_8000);
    rd("count wrapped", 5'd9, 32'h0000_0001);
    repeat (4) edge_tick();
    rd("timer held", 5'd13, 32'h0000_8000);
    rd("count later", 5'd9, 32'h0000_0003);
    mtc0(5'd11, 32'h0000_0100);
    rd("timer cleared", 5'd13, 32'h0000_0000);
`else
    mtc0(5'd9, 32'h0000_1234);
    rd("count off", 5'd9, 32'h0);
    mtc0(5'd11, 32'h0000_0005);
    rd("compare off", 5'd11, 32'h0);
    hw_int = 6'h20;
    edge_tick();
    rd("hw5 ip15", 5'd13, 32'h0000_8000);
    hw_int = 6'h00;
    edge_tick();
    rd("hw5 ip15 drop", 5'd13, 32'h0000_0000);
`endif

    // Reset in the middle of an exception with an interrupt pending
    hw_int = 6'h01;
    mtc0(5'd12, 32'h0000_0401);
    exc_we = 1'b1; exc_code = 5'd8; exc_epc = 32'h8000_0180;
    edge_tick();
    idle();
    chk("pre-rst exl", {31'b0, cp0_exl}, 32'h1);
    rd("pre-rst cause", 5'd13, 32'h0000_0420);
    rst_n = 1'b0;
    edge_tick();
    for (int a = 9; a < 15; a++) rd($sformatf("rst rd%0d", a), 5'(a), 32'h0);
    chk("rst exl", {31'b0, cp0_exl}, 32'h0);
    chk("rst epc", cp0_epc, 32'h0);
    chk("rst intr", {31'b0, cp0_intr}, 32'h0);
    rst_n = 1'b1; hw_int = 6'h00;
    edge_tick();
    chk("post-rst intr", {31'b0, cp0_intr}, 32'h0);
    rd("post-rst status", 5'd12, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
